fifo_in_ctrl: RTL and testbench

- Control and read-out stage for the 8-entry, 32-bit FIFO_IN register file.
- Accepts write/read requests and drives the file's 8-bit one-hot write enable.
- Receives the file's eight parallel word outputs and selects the head entry into a registered read-data output.
- Keeps head/tail pointers, an occupancy count and the full/empty/ack/error status seen by the rest of the Factorial Machine.

---
 rtl/fifo_in_ctrl.sv | 107 ++++++++++
 tb/tb_fifo_in_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fifo_in_ctrl.sv
// Control and head-select read-out for the 8-entry FIFO_IN register file.
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_IN_CTRL_LEVEL_EN.
module fifo_in_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic [WIDTH-1:0] rf_q0,
  input  logic [WIDTH-1:0] rf_q1,
  input  logic [WIDTH-1:0] rf_q2,
  input  logic [WIDTH-1:0] rf_q3,
  input  logic [WIDTH-1:0] rf_q4,
  input  logic [WIDTH-1:0] rf_q5,
  input  logic [WIDTH-1:0] rf_q6,
  input  logic [WIDTH-1:0] rf_q7,
  output logic [7:0]       rf_we,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [3:0]       data_count,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
`ifdef FIFO_IN_CTRL_LEVEL_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  logic [2:0]       head_q, head_d;
  logic [2:0]       tail_q, tail_d;
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] head_word;

  assign full       = (count_q == 4'd8);
  assign empty      = (count_q == 4'd0);
  assign data_count = count_q;

`ifdef FIFO_IN_CTRL_LEVEL_EN
  assign almost_full  = (count_q >= 4'd7);
  assign almost_empty = (count_q <= 4'd1);
`endif

  // Status is judged on the pre-edge count, so a full FIFO cannot be refilled in the same cycle.
  assign wr_ok = wr_req && !full;
  assign rd_ok = rd_req && !empty;

  assign rf_we = wr_ok ? (8'h01 << tail_q) : 8'h00;

  always_comb begin
    head_word = rf_q0;
    unique case (head_q)
      3'd0: head_word = rf_q0;
      3'd1: head_word = rf_q1;
      3'd2: head_word = rf_q2;
      3'd3: head_word = rf_q3;
      3'd4: head_word = rf_q4;
      3'd5: head_word = rf_q5;
      3'd6: head_word = rf_q6;
      3'd7: head_word = rf_q7;
      default: head_word = rf_q0;
    endcase
  end

  always_comb begin
    tail_d    = wr_ok ? tail_q + 3'd1 : tail_q;
    head_d    = rd_ok ? head_q + 3'd1 : head_q;
    rd_data_d = rd_ok ? head_word : rd_data_q;
    count_d   = count_q + {3'b000, wr_ok} - {3'b000, rd_ok};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q    <= 3'd0;
      tail_q    <= 3'd0;
      count_q   <= 4'd0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      wr_ack_q  <= wr_ok;
      wr_err_q  <= wr_req && full;
      rd_ack_q  <= rd_ok;
      rd_err_q  <= rd_req && empty;
    end
  end

  assign rd_data = rd_data_q;
  assign wr_ack  = wr_ack_q;
  assign wr_err  = wr_err_q;
  assign rd_ack  = rd_ack_q;
  assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_fifo_in_ctrl.sv
// Directed, table-driven bench for fifo_in_ctrl with an attached 8x32 register file model.
module tb_fifo_in_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_req, rd_req;
  logic [31:0] d_in;
  logic [31:0] rf [8];
  logic [7:0]  rf_we;
  logic [31:0] rd_data;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [3:0]  data_count;
`ifdef FIFO_IN_CTRL_LEVEL_EN
  logic        almost_full, almost_empty;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_in_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .rd_req(rd_req),
    .rf_q0(rf[0]), .rf_q1(rf[1]), .rf_q2(rf[2]), .rf_q3(rf[3]),
    .rf_q4(rf[4]), .rf_q5(rf[5]), .rf_q6(rf[6]), .rf_q7(rf[7]),
    .rf_we(rf_we), .rd_data(rd_data), .full(full), .empty(empty),
    .data_count(data_count), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err)
`ifdef FIFO_IN_CTRL_LEVEL_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  // Register file shares reset_n and captures d_in on the enabled entry.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 8; i++) if (rf_we[i]) rf[i] <= d_in;
    end
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [7:0]  we;
    logic [3:0]  cnt;
    logic        wa, werr, ra, rerr;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [31:0] din,
                     input logic [7:0] we, input logic [3:0] cnt,
                     input logic wa, input logic werr, input logic ra, input logic rerr,
                     input logic [31:0] rdat);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.we = we; v.cnt = cnt;
    v.wa = wa; v.werr = werr; v.ra = ra; v.rerr = rerr; v.rdat = rdat;
    vecs.push_back(v);
  endtask

  task automatic check_status(input string tag, input logic [3:0] cnt, input logic wa,
                              input logic werr, input logic ra, input logic rerr,
                              input logic [31:0] rdat);
    chk({tag, " count"}, 32'(data_count), 32'(cnt));
    chk({tag, " full"},  32'(full),  32'(cnt == 4'd8));
    chk({tag, " empty"}, 32'(empty), 32'(cnt == 4'd0));
    chk({tag, " wr_ack"}, 32'(wr_ack), 32'(wa));
    chk({tag, " wr_err"}, 32'(wr_err), 32'(werr));
    chk({tag, " rd_ack"}, 32'(rd_ack), 32'(ra));
    chk({tag, " rd_err"}, 32'(rd_err), 32'(rerr));
    chk({tag, " rd_data"}, rd_data, rdat);
`ifdef FIFO_IN_CTRL_LEVEL_EN
    chk({tag, " almost_full"},  32'(almost_full),  32'(cnt >= 4'd7));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 4'd1));
`endif
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] din);
    @(negedge clk);
    wr_req = wr; rd_req = rd; d_in = din;
  endtask

  initial begin
    reset_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; d_in = 32'h0;

    // Write 8 from empty, then an overflow attempt.
    for (int i = 1; i <= 8; i++)
      add(1, 0, 32'(i), 8'(8'h01 << (i - 1)), 4'(i), 1, 0, 0, 0, 32'h0);
    add(1, 0, 32'h9, 8'h00, 4'd8, 0, 1, 0, 0, 32'h0);
    // Drain 8 in order, then an underflow attempt.
    for (int i = 1; i <= 8; i++)
      add(0, 1, 32'h0, 8'h00, 4'(8 - i), 0, 0, 1, 0, 32'(i));
    add(0, 1, 32'h0, 8'h00, 4'd0, 0, 0, 0, 1, 32'h8);
    // Wrap-around: write 5, read 5, write 6, read 6.
    for (int i = 0; i < 5; i++)
      add(1, 0, 32'h11 + 32'(i), 8'(8'h01 << i), 4'(i + 1), 1, 0, 0, 0, 32'h8);
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'h0, 8'h00, 4'(4 - i), 0, 0, 1, 0, 32'h11 + 32'(i));
    for (int i = 0; i < 6; i++)
      add(1, 0, 32'h21 + 32'(i), 8'(8'h01 << ((5 + i) % 8)), 4'(i + 1), 1, 0, 0, 0, 32'h15);
    for (int i = 0; i < 6; i++)
      add(0, 1, 32'h0, 8'h00, 4'(5 - i), 0, 0, 1, 0, 32'h21 + 32'(i));
    // Tail is now 3: three writes at 08,10,20, then a simultaneous request at count 3.
    add(1, 0, 32'h31, 8'h08, 4'd1, 1, 0, 0, 0, 32'h26);
    add(1, 0, 32'h32, 8'h10, 4'd2, 1, 0, 0, 0, 32'h26);
    add(1, 0, 32'h33, 8'h20, 4'd3, 1, 0, 0, 0, 32'h26);
    add(1, 1, 32'h34, 8'h40, 4'd3, 1, 0, 1, 0, 32'h31);
    add(0, 1, 32'h0, 8'h00, 4'd2, 0, 0, 1, 0, 32'h32);
    add(0, 1, 32'h0, 8'h00, 4'd1, 0, 0, 1, 0, 32'h33);
    add(0, 1, 32'h0, 8'h00, 4'd0, 0, 0, 1, 0, 32'h34);
    // Simultaneous at empty: tail=7, head=7.
    add(1, 1, 32'h41, 8'h80, 4'd1, 1, 0, 0, 1, 32'h34);
    for (int i = 0; i < 7; i++)
      add(1, 0, 32'h42 + 32'(i), 8'(8'h01 << i), 4'(i + 2), 1, 0, 0, 0, 32'h34);
    // Simultaneous at full: head entry (0x41) out, write rejected.
    add(1, 1, 32'h49, 8'h00, 4'd7, 0, 1, 1, 0, 32'h41);
    add(0, 0, 32'h0, 8'h00, 4'd7, 0, 0, 0, 0, 32'h41);

    // Reset state while reset_n is held low.
    repeat (2) @(negedge clk);
    #1 chk("reset rf_we", 32'(rf_we), 32'h0);
    check_status("reset", 4'd0, 0, 0, 0, 0, 32'h0);
    reset_n = 1'b1;
    drive(0, 0, 32'h0);
    @(posedge clk); #1;
    check_status("idle", 4'd0, 0, 0, 0, 0, 32'h0);

    // Three writes, then asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) drive(1, 0, 32'hA0 + 32'(i));
    @(negedge clk);
    wr_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk("midrst rf_we", 32'(rf_we), 32'h0);
    check_status("midrst", 4'd0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      drive(vecs[k].wr, vecs[k].rd, vecs[k].din);
      #1 chk({tag, " rf_we"}, 32'(rf_we), 32'(vecs[k].we));
      @(posedge clk); #1;
      check_status(tag, vecs[k].cnt, vecs[k].wa, vecs[k].werr, vecs[k].ra, vecs[k].rerr,
                   vecs[k].rdat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
